// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use hazard detection, flush/stall control
// and a saturating count of the bubbles inserted for load-use hazards.
module id_ex_stage #(
  parameter int DATA_W = 32,
  parameter int PC_W   = 9
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              id_valid,
  input  logic [PC_W-1:0]   id_pc,
  input  logic [DATA_W-1:0] id_rd1,
  input  logic [DATA_W-1:0] id_rd2,
  input  logic [DATA_W-1:0] id_imm,
  input  logic [4:0]        id_rs1,
  input  logic [4:0]        id_rs2,
  input  logic [4:0]        id_rd,
  input  logic [9:0]        id_funct,
  input  logic [7:0]        id_ctrl,
  input  logic              ex_flush,
  input  logic              ex_stall,
  output logic              ex_valid,
  output logic [PC_W-1:0]   ex_pc,
  output logic [DATA_W-1:0] ex_rd1,
  output logic [DATA_W-1:0] ex_rd2,
  output logic [DATA_W-1:0] ex_imm,
  output logic [4:0]        ex_rs1,
  output logic [4:0]        ex_rs2,
  output logic [4:0]        ex_rd,
  output logic [9:0]        ex_funct,
  output logic [7:0]        ex_ctrl,
  output logic              hazard_stall,
  output logic [15:0]       bubble_count
);

  // Control byte layout: {Branch, ALUOp[1:0], MemWrite, MemRead, RegWrite, MemtoReg, ALUSrc}
  localparam int CTRL_MEM_READ = 3;

  typedef struct packed {
    logic              valid;
    logic [PC_W-1:0]   pc;
    logic [DATA_W-1:0] rd1;
    logic [DATA_W-1:0] rd2;
    logic [DATA_W-1:0] imm;
    logic [4:0]        rs1;
    logic [4:0]        rs2;
    logic [4:0]        rd;
    logic [9:0]        funct;
    logic [7:0]        ctrl;
  } idex_t;

  idex_t       id_pkt;
  idex_t       ex_q, ex_d;
  logic [15:0] bubble_count_q, bubble_count_d;

  // An invalid decode slot still carries its data, but never its controls.
  always_comb begin
    id_pkt.valid = id_valid;
    id_pkt.pc    = id_pc;
    id_pkt.rd1   = id_rd1;
    id_pkt.rd2   = id_rd2;
    id_pkt.imm   = id_imm;
    id_pkt.rs1   = id_rs1;
    id_pkt.rs2   = id_rs2;
    id_pkt.rd    = id_rd;
    id_pkt.funct = id_funct;
    id_pkt.ctrl  = id_valid ? id_ctrl : 8'h00;
  end

  // A flush kills the consumer anyway, so no bubble is needed behind it.
  always_comb begin
    hazard_stall = ex_q.valid & ex_q.ctrl[CTRL_MEM_READ] & (ex_q.rd != 5'd0) &
                   id_valid & ((ex_q.rd == id_rs1) | (ex_q.rd == id_rs2)) & ~ex_flush;
  end

  always_comb begin
    // NOTE: defaults first so every path assigns the next state and no latch is inferred.
    ex_d           = ex_q;
    bubble_count_d = bubble_count_q;
    if (ex_flush) begin
      ex_d = '0;
    end else if (!ex_stall) begin
      if (hazard_stall) begin
        ex_d = '0;
        if (bubble_count_q != 16'hFFFF) bubble_count_d = bubble_count_q + 16'd1;
      end else begin
        ex_d = id_pkt;
      end
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments; reset is synchronous and wins over flush/stall.
    if (!reset) begin
      ex_q           <= '0;
      bubble_count_q <= '0;
    end else begin
      ex_q           <= ex_d;
      bubble_count_q <= bubble_count_d;
    end
  end

  assign ex_valid     = ex_q.valid;
  assign ex_pc        = ex_q.pc;
  assign ex_rd1       = ex_q.rd1;
  assign ex_rd2       = ex_q.rd2;
  assign ex_imm       = ex_q.imm;
  assign ex_rs1       = ex_q.rs1;
  assign ex_rs2       = ex_q.rs2;
  assign ex_rd        = ex_q.rd;
  assign ex_funct     = ex_q.funct;
  assign ex_ctrl      = ex_q.ctrl;
  assign bubble_count = bubble_count_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Bench for id_ex_stage: table of stimulus records with hand-derived hazard/valid/count
// expectations, plus a reference model whose predicted ID/EX contents go through a queue.
module tb_id_ex_stage;

  localparam int DATA_W = 32;
  localparam int PC_W   = 9;
  localparam logic [7:0] C_LW  = 8'h0F;
  localparam logic [7:0] C_ADD = 8'h44;
  localparam logic [7:0] C_ALU = 8'h04;

  logic              clk = 1'b0;
  logic              reset, id_valid, ex_flush, ex_stall;
  logic [PC_W-1:0]   id_pc;
  logic [DATA_W-1:0] id_rd1, id_rd2, id_imm;
  logic [4:0]        id_rs1, id_rs2, id_rd;
  logic [9:0]        id_funct;
  logic [7:0]        id_ctrl;
  logic              ex_valid, hazard_stall;
  logic [PC_W-1:0]   ex_pc;
  logic [DATA_W-1:0] ex_rd1, ex_rd2, ex_imm;
  logic [4:0]        ex_rs1, ex_rs2, ex_rd;
  logic [9:0]        ex_funct;
  logic [7:0]        ex_ctrl;
  logic [15:0]       bubble_count;

  always #5 clk = ~clk;

  id_ex_stage #(.DATA_W(DATA_W), .PC_W(PC_W)) dut (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_pc(id_pc),
    .id_rd1(id_rd1), .id_rd2(id_rd2), .id_imm(id_imm),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
    .id_funct(id_funct), .id_ctrl(id_ctrl),
    .ex_flush(ex_flush), .ex_stall(ex_stall),
    .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_rd1(ex_rd1), .ex_rd2(ex_rd2),
    .ex_imm(ex_imm), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd),
    .ex_funct(ex_funct), .ex_ctrl(ex_ctrl),
    .hazard_stall(hazard_stall), .bubble_count(bubble_count)
  );

  typedef struct packed {
    logic        rst_n;
    logic        valid;
    logic [8:0]  pc;
    logic [31:0] rd1, rd2, imm;
    logic [4:0]  rs1, rs2, rd;
    logic [9:0]  funct;
    logic [7:0]  ctrl;
    logic        flush, stall;
  } in_t;

  typedef struct packed {
    logic        valid;
    logic [8:0]  pc;
    logic [31:0] rd1, rd2, imm;
    logic [4:0]  rs1, rs2, rd;
    logic [9:0]  funct;
    logic [7:0]  ctrl;
    logic [15:0] count;
  } st_t;

  typedef struct {
    in_t         in;
    logic        exp_hz;
    logic        exp_valid;
    logic [15:0] exp_count;
  } vec_t;

  int   n_vec  = 0;
  int   n_miss = 0;
  st_t  model;
  st_t  sb_q[$];
  logic last_hz;
  vec_t tbl[18];

  task automatic check(input string name, input logic [191:0] act, input logic [191:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic in_t mk(input logic rst_n, input logic valid, input logic [8:0] pc,
                             input logic [31:0] rd1, input logic [4:0] rs1, input logic [4:0] rs2,
                             input logic [4:0] rd, input logic [7:0] ctrl,
                             input logic flush, input logic stall);
    in_t v;
    v.rst_n = rst_n;   v.valid = valid;  v.pc = pc;
    v.rd1   = rd1;     v.rd2   = ~rd1;   v.imm = {23'd0, pc};
    v.rs1   = rs1;     v.rs2   = rs2;    v.rd  = rd;
    v.funct = {rs2, rd};
    v.ctrl  = ctrl;    v.flush = flush;  v.stall = stall;
    return v;
  endfunction

  function automatic st_t dut_state();
    st_t s;
    s.valid = ex_valid; s.pc = ex_pc; s.rd1 = ex_rd1; s.rd2 = ex_rd2; s.imm = ex_imm;
    s.rs1 = ex_rs1; s.rs2 = ex_rs2; s.rd = ex_rd; s.funct = ex_funct; s.ctrl = ex_ctrl;
    s.count = bubble_count;
    return s;
  endfunction

  function automatic logic model_hz(input in_t v);
    return model.valid && model.ctrl[3] && (model.rd != 5'd0) && v.valid &&
           ((model.rd == v.rs1) || (model.rd == v.rs2)) && !v.flush;
  endfunction

  function automatic st_t model_next(input in_t v, input logic hz);
    st_t n;
    n = model;
    if (!v.rst_n) begin
      n = '0;
    end else if (v.flush) begin
      n = '0;
      n.count = model.count;
    end else if (v.stall) begin
      n = model;
    end else if (hz) begin
      n = '0;
      n.count = (model.count == 16'hFFFF) ? 16'hFFFF : model.count + 16'd1;
    end else begin
      n.valid = v.valid; n.pc = v.pc; n.rd1 = v.rd1; n.rd2 = v.rd2; n.imm = v.imm;
      n.rs1 = v.rs1; n.rs2 = v.rs2; n.rd = v.rd; n.funct = v.funct;
      n.ctrl = v.valid ? v.ctrl : 8'h00;
      n.count = model.count;
    end
    return n;
  endfunction

  task automatic drive(input in_t v);
    reset = v.rst_n; id_valid = v.valid; id_pc = v.pc;
    id_rd1 = v.rd1; id_rd2 = v.rd2; id_imm = v.imm;
    id_rs1 = v.rs1; id_rs2 = v.rs2; id_rd = v.rd;
    id_funct = v.funct; id_ctrl = v.ctrl;
    ex_flush = v.flush; ex_stall = v.stall;
  endtask

  // Called just after a rising edge: drive, check the combinational stall request at
  // the falling edge, then compare the registered contents after the next rising edge.
  task automatic apply(input in_t v);
    logic hz;
    st_t  exp;
    drive(v);
    @(negedge clk);
    hz      = model_hz(v);
    last_hz = hazard_stall;
    check("hazard_stall", 192'(hazard_stall), 192'(hz));
    sb_q.push_back(model_next(v, hz));
    @(posedge clk);
    #1;
    if (sb_q.size() == 0) begin
      check("scoreboard_empty", 192'(1), 192'(0));
    end else begin
      exp   = sb_q.pop_front();
      check("ex_regs", 192'(dut_state()), 192'(exp));
      model = exp;
    end
  endtask

  initial begin
    logic [8:0] held_pc;
    in_t        v;

    tbl[0]  = '{mk(1, 1, 9'h04, 32'h5,   1,  2,  3, C_ALU, 0, 0), 1'b0, 1'b1, 16'd0};
    tbl[1]  = '{mk(1, 1, 9'h08, 32'h100, 2,  0,  5, C_LW,  0, 0), 1'b0, 1'b1, 16'd0};
    tbl[2]  = '{mk(1, 1, 9'h0C, 32'h7,   1,  5,  6, C_ADD, 0, 0), 1'b1, 1'b0, 16'd1};
    tbl[3]  = '{mk(1, 1, 9'h0C, 32'h7,   1,  5,  6, C_ADD, 0, 0), 1'b0, 1'b1, 16'd1};
    tbl[4]  = '{mk(1, 1, 9'h10, 32'h8,   6,  0,  0, C_LW,  0, 0), 1'b0, 1'b1, 16'd1};
    tbl[5]  = '{mk(1, 1, 9'h14, 32'h9,   0,  0,  7, C_ALU, 0, 0), 1'b0, 1'b1, 16'd1};
    tbl[6]  = '{mk(1, 1, 9'h18, 32'hA,   7,  0,  8, C_LW,  0, 0), 1'b0, 1'b1, 16'd1};
    tbl[7]  = '{mk(1, 1, 9'h1C, 32'hB,   8,  1,  9, C_ADD, 1, 0), 1'b0, 1'b0, 16'd1};
    tbl[8]  = '{mk(1, 0, 9'h20, 32'hC,   8,  0, 10, C_LW,  0, 0), 1'b0, 1'b0, 16'd1};
    tbl[9]  = '{mk(1, 1, 9'h24, 32'hD,   1,  2, 11, C_LW,  0, 0), 1'b0, 1'b1, 16'd1};
    tbl[10] = '{mk(1, 0, 9'h28, 32'hE,  11,  0,  1, C_ADD, 0, 0), 1'b0, 1'b0, 16'd1};
    tbl[11] = '{mk(1, 1, 9'h2C, 32'hF,   1,  2, 12, C_LW,  0, 0), 1'b0, 1'b1, 16'd1};
    tbl[12] = '{mk(1, 1, 9'h30, 32'h10,  3, 12, 13, C_ADD, 0, 1), 1'b1, 1'b1, 16'd1};
    tbl[13] = '{mk(1, 1, 9'h30, 32'h10,  3, 12, 13, C_ADD, 0, 1), 1'b1, 1'b1, 16'd1};
    tbl[14] = '{mk(1, 1, 9'h30, 32'h10,  3, 12, 13, C_ADD, 0, 0), 1'b1, 1'b0, 16'd2};
    tbl[15] = '{mk(1, 1, 9'h30, 32'h10,  3, 12, 13, C_ADD, 0, 0), 1'b0, 1'b1, 16'd2};
    tbl[16] = '{mk(0, 1, 9'h34, 32'h11, 13,  0, 14, C_LW,  0, 1), 1'b0, 1'b0, 16'd0};
    tbl[17] = '{mk(0, 1, 9'h38, 32'h12,  1,  2,  3, C_ADD, 1, 0), 1'b0, 1'b0, 16'd0};

    // Reset with busy flush/stall inputs must still clear everything.
    drive(mk(0, 1, 9'h1FF, 32'hDEAD_BEEF, 1, 2, 3, C_LW, 1, 1));
    repeat (2) @(posedge clk);
    #1;
    check("reset_state", 192'(dut_state()), 192'(0));
    model = '0;

    // First cycle out of reset: EX is empty, so no stall even with matching indices.
    apply(mk(1, 1, 9'h00, 32'h0, 0, 0, 0, C_LW, 0, 0));
    check("post_reset_hz", 192'(last_hz), 192'(0));

    for (int i = 0; i < 18; i++) begin
      apply(tbl[i].in);
      check($sformatf("tbl%0d_hz", i),    192'(last_hz),      192'(tbl[i].exp_hz));
      check($sformatf("tbl%0d_valid", i), 192'(ex_valid),     192'(tbl[i].exp_valid));
      check($sformatf("tbl%0d_count", i), 192'(bubble_count), 192'(tbl[i].exp_count));
    end
    check("normal_pc", 192'(ex_pc), 192'(0));

    // Stall hold: three stalled cycles with changing decode contents, then release.
    apply(mk(1, 1, 9'h40, 32'h1234, 1, 2, 3, C_ADD, 0, 0));
    held_pc = ex_pc;
    check("stall_load_pc", 192'(held_pc), 192'(9'h40));
    for (int i = 0; i < 3; i++) begin
      v = mk(1, 1, 9'($urandom_range(9'h41, 9'h1FF)), $urandom, 5'($urandom), 5'($urandom),
             5'($urandom), 8'($urandom), 0, 1);
      apply(v);
      check($sformatf("stall_hold_pc%0d", i), 192'(ex_pc), 192'(9'h40));
    end
    apply(mk(1, 1, 9'h44, 32'h5678, 4, 5, 6, C_ALU, 0, 0));
    check("stall_release_pc",  192'(ex_pc),  192'(9'h44));
    check("stall_release_rd1", 192'(ex_rd1), 192'(32'h5678));

    // Saturation: preload the counter just below its ceiling, then insert two bubbles.
    force dut.bubble_count_q = 16'hFFFE;
    #1;
    release dut.bubble_count_q;
    model.count = 16'hFFFE;
    apply(mk(1, 1, 9'h50, 32'h1, 1, 2, 3, C_LW, 0, 0));
    check("sat_preload", 192'(bubble_count), 192'(16'hFFFE));
    apply(mk(1, 1, 9'h54, 32'h2, 3, 0, 3, C_LW, 0, 0));
    check("sat_first",   192'(bubble_count), 192'(16'hFFFF));
    apply(mk(1, 1, 9'h54, 32'h2, 3, 0, 3, C_LW, 0, 0));
    apply(mk(1, 1, 9'h54, 32'h2, 3, 0, 3, C_LW, 0, 0));
    check("sat_hz",      192'(last_hz),      192'(1));
    check("sat_hold",    192'(bubble_count), 192'(16'hFFFF));
    apply(mk(0, 1, 9'h58, 32'h3, 3, 0, 3, C_LW, 0, 1));
    check("sat_reset",   192'(dut_state()),  192'(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/id_ex_stage.md
ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 Parameter DATA_W, default 32, datapath operand/immediate width.
REQ-002 Parameter PC_W, default 9, program-counter width.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-low; reset=0 at a rising edge clears all state.
REQ-005 id_valid  input  1  decode-stage instruction is valid.
REQ-006 id_pc  input  PC_W  decode-stage PC.
REQ-007 id_rd1  input  DATA_W  register-file read data 1.
REQ-008 id_rd2  input  DATA_W  register-file read data 2.
REQ-009 id_imm  input  DATA_W  sign-extended immediate.
REQ-010 id_rs1  input  5  source register 1 index.
REQ-011 id_rs2  input  5  source register 2 index.
REQ-012 id_rd  input  5  destination register index.
REQ-013 id_funct  input  10  {funct7, funct3}.
REQ-014 id_ctrl  input  8  decoder controls {Branch, ALUOp[1:0], MemWrite, MemRead, RegWrite, MemtoReg, ALUSrc}.
REQ-015 ex_flush  input  1  branch taken in EX; kill the instruction entering EX.
REQ-016 ex_stall  input  1  downstream hold; freeze ID/EX contents.
REQ-017 ex_valid, ex_pc, ex_rd1, ex_rd2, ex_imm, ex_rs1, ex_rs2, ex_rd, ex_funct, ex_ctrl  output  widths as id_*  registered ID/EX contents.
REQ-018 hazard_stall  output  1  combinational load-use stall request to PC and IF/ID (hold).
REQ-019 bubble_count  output  16  saturating count of load-use bubbles inserted.

Function
REQ-020 Latency SHALL be exactly one cycle from id_* to ex_* under normal advance.
REQ-021 hazard_stall SHALL equal ex_valid & ex_ctrl[MemRead] & (ex_rd!=0) & id_valid & ((ex_rd==id_rs1)|(ex_rd==id_rs2)) & !ex_flush, same cycle.
REQ-022 Per rising edge with reset=1, priority SHALL be: flush > ex_stall > hazard bubble > normal advance.
REQ-023 Flush: ex_valid<=0, ex_ctrl<=0, all other ex_* data fields <=0.
REQ-024 ex_stall (no flush): all ex_* registers and bubble_count SHALL hold; hazard_stall still computed per REQ-021.
REQ-025 Hazard bubble (hazard_stall=1, no flush/stall): ex_valid<=0, ex_ctrl<=0, data fields <=0; bubble_count increments by 1.
REQ-026 Normal advance: all ex_* <= id_*; ex_ctrl SHALL load 0 when id_valid=0.
REQ-027 bubble_count SHALL saturate at 16'hFFFF and never wrap.
REQ-028 A bubbled instruction SHALL have ex_valid=0, so REQ-021 cannot re-trigger on it; a load-use stall lasts exactly one cycle absent ex_stall.
REQ-029 ex_rd==0 SHALL never cause a hazard (x0 writes are discarded).
REQ-030 ex_flush coinciding with a hazard condition SHALL flush only: hazard_stall=0, bubble_count unchanged.

Reset
REQ-031 With reset=0 at a rising edge: every ex_* output =0, ex_valid=0, bubble_count=0, regardless of flush/stall inputs.
REQ-032 hazard_stall SHALL read 0 in the cycle after reset (ex_valid=0).
REQ-033 Reset asserted mid-stall or mid-flush SHALL take effect at that edge; no prior state is retained.

Verification
REQ-034 Normal: id_valid=1, id_pc=9'h04, id_rd1=32'h5, id_ctrl=8'h04 (RegWrite) -> next cycle ex_pc=9'h04, ex_rd1=32'h5, ex_ctrl=8'h04, ex_valid=1.
REQ-035 Load-use: EX holds LW (ex_ctrl MemRead, ex_rd=5), ID add with id_rs2=5 -> hazard_stall=1 same cycle; next cycle ex_valid=0, ex_ctrl=0, bubble_count=1, hazard_stall=0.
REQ-036 x0 load: EX LW with ex_rd=0, id_rs1=0 -> hazard_stall=0, instruction advances.
REQ-037 Flush+hazard: load-use condition with ex_flush=1 -> hazard_stall=0; next cycle ex_valid=0, bubble_count unchanged.
REQ-038 Stall hold: ex_stall=1 for 3 cycles with changing id_* -> ex_* constant; release -> captures current id_*.
REQ-039 Saturation/reset: preload bubble_count to 16'hFFFE, two bubbles -> 16'hFFFF held; reset=0 one edge -> all outputs 0.
